// File: rtl/trace_pkg.sv
// Shared types and default geometry for the trace buffer write side.
package trace_pkg;
    `include "util.vh"

    localparam int TRACE_WIDTH = 18;
    localparam int TRACE_DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        DONE
    } capture_state_t;
endpackage

// File: rtl/trace_trig_match.sv
// Trigger qualifier: mask/value captured on arm, compare is combinational.
// Zero latency on the compare; no backpressure, evaluates every cycle.
module trace_trig_match
    import trace_pkg::*;
#(
    parameter int Width = TRACE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] cfg_mask,
    input  logic [Width-1:0] cfg_value,
    input  logic             sample_valid,
    input  logic [Width-1:0] sample_data,
    output logic             match
);

    logic [Width-1:0] mask_q;
    logic [Width-1:0] value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q  <= '0;
            value_q <= '0;
        end else if (load) begin
            mask_q  <= cfg_mask;
            value_q <= cfg_value;
        end
    end

    // A zero mask matches any valid sample.
    assign match = sample_valid && (((sample_data ^ value_q) & mask_q) == '0);

endmodule

// File: rtl/util.vh
// Elaboration-time helpers shared across the trace capture design.
`ifndef TRACE_UTIL_VH
`define TRACE_UTIL_VH
function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
        if ((1 << i) < value) begin
            r = i + 1;
        end
    end
    return r;
endfunction
`endif

// File: rtl/trace_capture_ctrl.sv
// Circular trace writer: fills RAM around a trigger, then freezes for readout.
// Write port is registered (1-cycle latency); no backpressure, invalid samples skip.
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter  int Width    = TRACE_WIDTH,
    parameter  int Depth    = TRACE_DEPTH,
    localparam int AddrBits = clog2(Depth)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic [AddrBits-1:0] cfg_pre_trig,
    input  logic [Width-1:0]    cfg_trig_mask,
    input  logic [Width-1:0]    cfg_trig_value,
    input  logic                sample_valid,
    input  logic [Width-1:0]    sample_data,
    output logic                wr_en,
    output logic [AddrBits-1:0] wr_addr,
    output logic [Width-1:0]    wr_data,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    output logic [AddrBits-1:0] trig_addr,
    output logic [AddrBits-1:0] start_addr
);

    localparam logic [AddrBits-1:0] LAST_ADDR = AddrBits'(Depth - 1);
    localparam logic [AddrBits:0]   DEPTH_EXT = (AddrBits + 1)'(Depth);

    capture_state_t state, state_nxt;

    logic [AddrBits-1:0] pre_q;
    logic [AddrBits-1:0] ptr_q;
    logic [AddrBits-1:0] count_q;
    logic [AddrBits-1:0] post_left_q;

    logic                arm_ok;
    logic                capturing;
    logic                wr_go;
    logic                match;
    logic                trig_hit;
    logic [AddrBits-1:0] pre_sel;
    logic [AddrBits-1:0] count_inc;
    logic [AddrBits-1:0] post_init;
    logic [AddrBits:0]   start_diff;
    logic [AddrBits-1:0] start_calc;

    assign arm_ok    = arm && !abort && (state == IDLE || state == DONE);
    assign capturing = (state == PRE) || (state == WAIT) || (state == POST);
    assign wr_go     = capturing && sample_valid && !abort;
    assign trig_hit  = (state == WAIT) && wr_go && match;
    assign pre_sel   = (cfg_pre_trig > LAST_ADDR) ? LAST_ADDR : cfg_pre_trig;
    assign count_inc = count_q + 1'b1;
    assign post_init = LAST_ADDR - pre_q;

    // Oldest retained sample sits pre entries behind the trigger, wrapping at Depth.
    always_comb begin
        start_diff = {1'b0, ptr_q} - {1'b0, pre_q};
        if (start_diff[AddrBits]) begin
            start_diff = start_diff + DEPTH_EXT;
        end
        start_calc = start_diff[AddrBits-1:0];
    end

    trace_trig_match #(
        .Width(Width)
    ) u_trig_match (
        .clk         (clk),
        .rst         (rst),
        .load        (arm_ok),
        .cfg_mask    (cfg_trig_mask),
        .cfg_value   (cfg_trig_value),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .match       (match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm_ok) begin
                        state_nxt = (pre_sel == '0) ? WAIT : PRE;
                    end
                end
                PRE: begin
                    if (wr_go && count_inc == pre_q) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (trig_hit) begin
                        state_nxt = (post_init == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (wr_go && post_left_q == AddrBits'(1)) begin
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            ptr_q       <= '0;
            pre_q       <= '0;
            count_q     <= '0;
            post_left_q <= '0;
            triggered   <= 1'b0;
            trig_addr   <= '0;
            start_addr  <= '0;
        end else begin
            wr_en <= wr_go;
            if (wr_go) begin
                wr_addr <= ptr_q;
                wr_data <= sample_data;
                ptr_q   <= (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
            end

            if (abort) begin
                triggered  <= 1'b0;
                trig_addr  <= '0;
                start_addr <= '0;
            end else if (arm_ok) begin
                pre_q      <= pre_sel;
                ptr_q      <= '0;
                count_q    <= '0;
                triggered  <= 1'b0;
                trig_addr  <= '0;
                start_addr <= '0;
            end else begin
                if (state == PRE && wr_go) begin
                    count_q <= count_inc;
                end
                if (trig_hit) begin
                    trig_addr   <= ptr_q;
                    start_addr  <= start_calc;
                    triggered   <= 1'b1;
                    post_left_q <= post_init;
                end
                if (state == POST && wr_go) begin
                    post_left_q <= post_left_q - 1'b1;
                end
            end
        end
    end

    assign busy = capturing;
    assign done = (state == DONE);

endmodule
